// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and default constants for the push-button debouncer
package debounce_pkg;

    typedef enum logic [2:0] {
        RELEASED   = 3'd0,
        DB_PRESS   = 3'd1,
        PRESSED    = 3'd2,
        HELD       = 3'd3,
        DB_RELEASE = 3'd4
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_HOLD_CYCLES     = 25000000;
    localparam int DEF_REPEAT_CYCLES   = 5000000;
    localparam int DEF_REPEAT_EN       = 1;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - generic N-flop single-bit synchroniser with asynchronous reset
// Ports:
//   myclk - destination clock
//   reset - asynchronous, active-high; clears every stage
//   d     - asynchronous input level
//   q     - synchronised level (last stage)
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic myclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge myclk or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button conditioner: synchroniser, debounce FSM, press/release pulses, long-press and auto-repeat
// Ports:
//   myclk         - system clock
//   reset         - asynchronous, active-high
//   button_raw    - unsynchronised pad level, 1 = pressed
//   button_clean  - debounced level
//   press_pulse   - one cycle when button_clean rises
//   release_pulse - one cycle when button_clean falls
//   held          - long-press level
//   repeat_pulse  - one-cycle auto-repeat strobe while held
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic myclk,
    input  logic reset,
    input  logic button_raw,
    output logic button_clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic held,
    output logic repeat_pulse
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW  = $clog2(HOLD_CYCLES) + 1;
    localparam int RW  = $clog2(REPEAT_CYCLES) + 1;

    localparam logic [DBW-1:0] DB_TERM   = DBW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0]  HOLD_TERM = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0]  REP_TERM  = RW'(REPEAT_CYCLES);
    localparam logic           REP_ON    = (REPEAT_EN != 0);

    logic s;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .myclk (myclk),
        .reset (reset),
        .d     (button_raw),
        .q     (s)
    );

    state_t         state, state_n;
    logic [DBW-1:0] db_cnt, db_n, db_inc;
    logic [HW-1:0]  hold_cnt, hold_n, hold_inc;
    logic [RW-1:0]  rep_cnt, rep_n, rep_inc;
    logic           clean_n, press_n, release_n, held_n, repeat_n;

    // Debounce and hold counters saturate; the repeat counter wraps explicitly below.
    assign db_inc   = (db_cnt == DB_TERM) ? db_cnt : db_cnt + DBW'(1);
    assign hold_inc = (hold_cnt == HOLD_TERM) ? hold_cnt : hold_cnt + HW'(1);
    assign rep_inc  = rep_cnt + RW'(1);

    always_ff @(posedge myclk or posedge reset) begin
        if (reset) begin
            state         <= RELEASED;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            button_clean  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_n;
            db_cnt        <= db_n;
            hold_cnt      <= hold_n;
            rep_cnt       <= rep_n;
            button_clean  <= clean_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            held          <= held_n;
            repeat_pulse  <= repeat_n;
        end
    end

    always_comb begin
        state_n   = state;
        db_n      = db_cnt;
        hold_n    = hold_cnt;
        rep_n     = rep_cnt;
        clean_n   = button_clean;
        held_n    = held;
        press_n   = 1'b0;
        release_n = 1'b0;
        repeat_n  = 1'b0;

        case (state)
            RELEASED: begin
                clean_n = 1'b0;
                held_n  = 1'b0;
                if (s) begin
                    state_n = DB_PRESS;
                    db_n    = DBW'(1);
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    state_n = RELEASED;
                    db_n    = '0;
                end else if (db_inc == DB_TERM) begin
                    state_n = PRESSED;
                    db_n    = '0;
                    clean_n = 1'b1;
                    press_n = 1'b1;
                    hold_n  = '0;
                end else begin
                    db_n = db_inc;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_n = DB_RELEASE;
                    db_n    = DBW'(1);
                end else if (hold_inc == HOLD_TERM) begin
                    state_n  = HELD;
                    hold_n   = hold_inc;
                    held_n   = 1'b1;
                    repeat_n = REP_ON;
                    rep_n    = '0;
                end else begin
                    hold_n = hold_inc;
                end
            end
            HELD: begin
                if (!s) begin
                    state_n = DB_RELEASE;
                    db_n    = DBW'(1);
                end else if (rep_inc == REP_TERM) begin
                    rep_n    = '0;
                    repeat_n = REP_ON;
                end else begin
                    rep_n = rep_inc;
                end
            end
            DB_RELEASE: begin
                // A bounce back to 1 resumes where it left off; frozen counters are untouched.
                if (s) begin
                    state_n = held ? HELD : PRESSED;
                    db_n    = '0;
                end else if (db_inc == DB_TERM) begin
                    state_n   = RELEASED;
                    db_n      = '0;
                    clean_n   = 1'b0;
                    held_n    = 1'b0;
                    release_n = 1'b1;
                end else begin
                    db_n = db_inc;
                end
            end
            default: begin
                state_n = RELEASED;
                db_n    = '0;
                hold_n  = '0;
                rep_n   = '0;
                clean_n = 1'b0;
                held_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
module tb_button_debouncer;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic myclk;
    logic reset;
    logic button_raw;
    logic clean, press, rel, held, rpt;
    logic nr_clean, nr_press, nr_rel, nr_held, nr_rpt;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    button_debouncer #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .REPEAT_EN(1)
    ) dut (
        .myclk(myclk), .reset(reset), .button_raw(button_raw),
        .button_clean(clean), .press_pulse(press), .release_pulse(rel),
        .held(held), .repeat_pulse(rpt)
    );

    button_debouncer #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .REPEAT_EN(0)
    ) dut_nr (
        .myclk(myclk), .reset(reset), .button_raw(button_raw),
        .button_clean(nr_clean), .press_pulse(nr_press), .release_pulse(nr_rel),
        .held(nr_held), .repeat_pulse(nr_rpt)
    );

    initial begin
        myclk = 1'b0;
        forever #5 myclk = ~myclk;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference model: run-length view of the synchronised input relative to the
    // accepted level, plus accumulated pressed time and repeat phase.
    logic [SYNC-1:0] hist;
    int  m_run, m_hold, m_phase;
    bit  m_clean, m_held;
    bit  e_press, e_rel, e_rpt;
    logic sv;

    initial begin
        hist = '0; m_run = 0; m_hold = 0; m_phase = 0;
        m_clean = 0; m_held = 0; e_press = 0; e_rel = 0; e_rpt = 0;
        forever begin
            @(posedge myclk or posedge reset);
            if (reset) begin
                hist = '0; m_run = 0; m_hold = 0; m_phase = 0;
                m_clean = 0; m_held = 0; e_press = 0; e_rel = 0; e_rpt = 0;
            end else begin
                sv = hist[SYNC-1];
                hist = {hist[SYNC-2:0], button_raw};
                e_press = 0; e_rel = 0; e_rpt = 0;
                if (!m_clean) begin
                    if (sv) begin
                        m_run++;
                        if (m_run == DB) begin
                            m_clean = 1; e_press = 1; m_run = 0; m_hold = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end else if (!sv) begin
                    m_run++;
                    if (m_run == DB) begin
                        m_clean = 0; m_held = 0; e_rel = 1; m_run = 0;
                    end
                end else if (m_run > 0) begin
                    m_run = 0;
                end else if (!m_held) begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        m_held = 1; e_rpt = 1; m_phase = 0;
                    end
                end else begin
                    m_phase++;
                    if (m_phase == REP) begin
                        m_phase = 0; e_rpt = 1;
                    end
                end
            end
        end
    end

    always @(negedge myclk) begin
        if (started) begin
            chk("m_clean",    clean,    m_clean);
            chk("m_press",    press,    e_press);
            chk("m_release",  rel,      e_rel);
            chk("m_held",     held,     m_held);
            chk("m_repeat",   rpt,      e_rpt);
            chk("nr_clean",   nr_clean, m_clean);
            chk("nr_press",   nr_press, e_press);
            chk("nr_release", nr_rel,   e_rel);
            chk("nr_held",    nr_held,  m_held);
            chk("nr_repeat",  nr_rpt,   1'b0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge myclk);
    endtask

    initial begin
        reset = 1'b1;
        button_raw = 1'b0;
        tick(3);
        chk("rst_clean", clean, 1'b0);
        chk("rst_press", press, 1'b0);
        chk("rst_release", rel, 1'b0);
        chk("rst_held", held, 1'b0);
        chk("rst_repeat", rpt, 1'b0);
        reset = 1'b0;
        started = 1;
        tick(3);

        // Stable press: raw rises before edge e0
        button_raw = 1'b1;
        tick(5);
        chk("s1_clean_e4", clean, 1'b0);
        tick(1);
        chk("s1_clean_e5", clean, 1'b1);
        chk("s1_press_e5", press, 1'b1);
        tick(1);
        chk("s1_press_e6", press, 1'b0);

        // Long hold: held and first repeat 10 cycles after clean rose
        tick(8);
        chk("s3_held_e14", held, 1'b0);
        tick(1);
        chk("s3_held_e15", held, 1'b1);
        chk("s3_rpt_e15", rpt, 1'b1);
        chk("s6_held_e15", nr_held, 1'b1);
        chk("s6_rpt_e15", nr_rpt, 1'b0);
        tick(1);
        chk("s3_rpt_e16", rpt, 1'b0);
        tick(2);
        chk("s3_rpt_e18", rpt, 1'b1);
        tick(3);
        chk("s3_rpt_e21", rpt, 1'b1);

        // Stable release: clean and held drop 5 cycles after raw falls
        button_raw = 1'b0;
        tick(5);
        chk("s4_clean_r4", clean, 1'b1);
        tick(1);
        chk("s4_clean_r5", clean, 1'b0);
        chk("s4_held_r5", held, 1'b0);
        chk("s4_rel_r5", rel, 1'b1);
        tick(1);
        chk("s4_rel_r6", rel, 1'b0);

        // Press bounce: 1,1,1,0 then stable 1
        tick(3);
        button_raw = 1'b1;
        tick(3);
        button_raw = 1'b0;
        tick(1);
        button_raw = 1'b1;
        tick(5);
        chk("s2_clean_b8", clean, 1'b0);
        tick(1);
        chk("s2_clean_b9", clean, 1'b1);
        chk("s2_press_b9", press, 1'b1);

        // Release glitch in PRESSED: 2 low samples, then high again
        tick(2);
        button_raw = 1'b0;
        tick(2);
        button_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("s4_glitch_clean", clean, 1'b1);
            chk("s4_glitch_rel", rel, 1'b0);
        end
        chk("s4_held_late_0", held, 1'b0);
        tick(1);
        chk("s4_held_late_1", held, 1'b1);
        chk("s4_rpt_late_1", rpt, 1'b1);

        // Reset mid-hold with the button still pressed
        #2 reset = 1'b1;
        #1;
        chk("s5_clean", clean, 1'b0);
        chk("s5_held", held, 1'b0);
        chk("s5_press", press, 1'b0);
        chk("s5_rel", rel, 1'b0);
        chk("s5_rpt", rpt, 1'b0);
        chk("s5_nr_held", nr_held, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("s5_clean_e5", clean, 1'b0);
        tick(1);
        chk("s5_clean_e6", clean, 1'b1);
        chk("s5_press_e6", press, 1'b1);

        button_raw = 1'b0;
        tick(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
